// File: rtl/core_sequencer_pkg.sv
// rtl/core_sequencer_pkg.sv - state encodings and instruction-class helpers for the core sequencer
package core_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_FAULT  = 3'd7
    } state_e;

    // IDU instruction classes; any nonzero class not listed here (ALU, jump, ...) writes rd and skips MEM
    localparam logic [31:0] INST_ILLEGAL = 32'd0;
    localparam logic [31:0] INST_LOAD    = 32'd2;
    localparam logic [31:0] INST_STORE   = 32'd3;
    localparam logic [31:0] INST_BRANCH  = 32'd4;

    function automatic logic is_mem(input logic [31:0] t);
        return (t == INST_LOAD) || (t == INST_STORE);
    endfunction

    function automatic logic writes_rd(input logic [31:0] t);
        return (t != INST_STORE) && (t != INST_BRANCH);
    endfunction

endpackage

// File: rtl/core_sequencer_stage_watchdog.sv
// rtl/core_sequencer_stage_watchdog.sv - per-stage wait counter with timeout compare
module core_sequencer_stage_watchdog #(
    parameter int WD_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [WD_W-1:0] LIMIT = WD_W'(TIMEOUT);

    logic [WD_W-1:0] cnt_q;
    logic [WD_W-1:0] cnt_d;

    // Count wait cycles, restarting on every state entry and saturating at the limit
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + WD_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == LIMIT);

endmodule

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle fetch/decode/execute/memory/writeback control FSM
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int INST_TYPE_W = 6,
    parameter int TIMEOUT     = 255,
    parameter int WD_W        = 8,
    parameter int CNT_W       = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   run,
    output logic                   ifu_req,
    input  logic                   ifu_resp,
    output logic                   idu_req,
    input  logic                   idu_resp,
    input  logic [INST_TYPE_W-1:0] inst_type,
    output logic                   exu_req,
    input  logic                   exu_resp,
    input  logic                   ebreak,
    output logic                   lsu_req,
    input  logic                   lsu_resp,
    output logic                   rf_we,
    output logic                   pc_we,
    output logic                   retired,
    output logic [CNT_W-1:0]       instret,
    output logic                   halted,
    output logic                   fault,
    output logic [2:0]             fault_stage
);

    state_e                 state_q, state_d;
    logic [INST_TYPE_W-1:0] itype_q, itype_d;
    logic                   ifu_req_q, ifu_req_d;
    logic                   idu_req_q, idu_req_d;
    logic                   exu_req_q, exu_req_d;
    logic                   lsu_req_q, lsu_req_d;
    logic                   rf_we_q, rf_we_d;
    logic                   pc_we_q, pc_we_d;
    logic                   retired_q, retired_d;
    logic [CNT_W-1:0]       instret_q, instret_d;
    logic                   halted_q, halted_d;
    logic                   fault_q, fault_d;
    logic [2:0]             fault_stage_q, fault_stage_d;

    logic entering;
    logic wd_enable;
    logic wd_expired;

    assign entering  = (state_d != state_q);
    assign wd_enable = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                       (state_q == ST_EXEC)  || (state_q == ST_MEM);

    core_sequencer_stage_watchdog #(
        .WD_W    (WD_W),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (entering),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // Next-state selection plus registered-output decode; a resp in its req cycle is not accepted
    always_comb begin
        state_d       = state_q;
        itype_d       = itype_q;
        instret_d     = instret_q;
        halted_d      = halted_q;
        fault_d       = fault_q;
        fault_stage_d = fault_stage_q;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (ifu_resp && !ifu_req_q) begin
                    state_d = ST_DECODE;
                end else if (wd_expired) begin
                    state_d       = ST_FAULT;
                    fault_d       = 1'b1;
                    fault_stage_d = state_q;
                end
            end
            ST_DECODE: begin
                if (idu_resp && !idu_req_q) begin
                    itype_d = inst_type;
                    if (32'(inst_type) == INST_ILLEGAL) begin
                        state_d       = ST_FAULT;
                        fault_d       = 1'b1;
                        fault_stage_d = state_q;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end else if (wd_expired) begin
                    state_d       = ST_FAULT;
                    fault_d       = 1'b1;
                    fault_stage_d = state_q;
                end
            end
            ST_EXEC: begin
                if (exu_resp && !exu_req_q) begin
                    if (ebreak) begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end else if (is_mem(32'(itype_q))) begin
                        state_d = ST_MEM;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wd_expired) begin
                    state_d       = ST_FAULT;
                    fault_d       = 1'b1;
                    fault_stage_d = state_q;
                end
            end
            ST_MEM: begin
                if (lsu_resp && !lsu_req_q) begin
                    state_d = ST_WB;
                end else if (wd_expired) begin
                    state_d       = ST_FAULT;
                    fault_d       = 1'b1;
                    fault_stage_d = state_q;
                end
            end
            ST_WB: begin
                state_d = run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
        endcase

        ifu_req_d = entering && (state_d == ST_FETCH);
        idu_req_d = entering && (state_d == ST_DECODE);
        exu_req_d = entering && (state_d == ST_EXEC);
        lsu_req_d = entering && (state_d == ST_MEM);

        pc_we_d   = (state_d == ST_WB);
        retired_d = (state_d == ST_WB);
        rf_we_d   = (state_d == ST_WB) && writes_rd(32'(itype_q));
        if (state_d == ST_WB) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    // FSM state and all registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            itype_q       <= '0;
            ifu_req_q     <= 1'b0;
            idu_req_q     <= 1'b0;
            exu_req_q     <= 1'b0;
            lsu_req_q     <= 1'b0;
            rf_we_q       <= 1'b0;
            pc_we_q       <= 1'b0;
            retired_q     <= 1'b0;
            instret_q     <= '0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
            fault_stage_q <= 3'd0;
        end else begin
            state_q       <= state_d;
            itype_q       <= itype_d;
            ifu_req_q     <= ifu_req_d;
            idu_req_q     <= idu_req_d;
            exu_req_q     <= exu_req_d;
            lsu_req_q     <= lsu_req_d;
            rf_we_q       <= rf_we_d;
            pc_we_q       <= pc_we_d;
            retired_q     <= retired_d;
            instret_q     <= instret_d;
            halted_q      <= halted_d;
            fault_q       <= fault_d;
            fault_stage_q <= fault_stage_d;
        end
    end

    assign ifu_req     = ifu_req_q;
    assign idu_req     = idu_req_q;
    assign exu_req     = exu_req_q;
    assign lsu_req     = lsu_req_q;
    assign rf_we       = rf_we_q;
    assign pc_we       = pc_we_q;
    assign retired     = retired_q;
    assign instret     = instret_q;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign fault_stage = fault_stage_q;

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - directed self-checking bench for core_sequencer
module tb_core_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        run;
    logic        ifu_req, idu_req, exu_req, lsu_req;
    logic        ifu_resp, idu_resp, exu_resp, lsu_resp;
    logic        ebreak;
    logic [5:0]  inst_type;
    logic        rf_we, pc_we, retired, halted, fault;
    logic [31:0] instret;
    logic [2:0]  fault_stage;

    int errors = 0;
    int checks = 0;
    int cyc;
    int dly_ifu, dly_idu, dly_exu, dly_lsu;
    int due_ifu, due_idu, due_exu, due_lsu;
    int n_ifu, n_idu, n_exu, n_lsu, n_ret;
    int t_ifu0, t_ifu1, t_idu0, t_exu0, t_lsu0, t_wb0, t_fault;
    int n_before;
    logic wb_rf, wb_pc;

    core_sequencer #(
        .INST_TYPE_W (6),
        .TIMEOUT     (4),
        .WD_W        (8),
        .CNT_W       (32)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .ifu_req     (ifu_req),
        .ifu_resp    (ifu_resp),
        .idu_req     (idu_req),
        .idu_resp    (idu_resp),
        .inst_type   (inst_type),
        .exu_req     (exu_req),
        .exu_resp    (exu_resp),
        .ebreak      (ebreak),
        .lsu_req     (lsu_req),
        .lsu_resp    (lsu_resp),
        .rf_we       (rf_we),
        .pc_we       (pc_we),
        .retired     (retired),
        .instret     (instret),
        .halted      (halted),
        .fault       (fault),
        .fault_stage (fault_stage)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        cyc = 0;
        n_ifu = 0; n_idu = 0; n_exu = 0; n_lsu = 0; n_ret = 0;
        t_ifu0 = -1; t_ifu1 = -1; t_idu0 = -1; t_exu0 = -1;
        t_lsu0 = -1; t_wb0 = -1; t_fault = -1;
        due_ifu = -1; due_idu = -1; due_exu = -1; due_lsu = -1;
        wb_rf = 1'b0; wb_pc = 1'b0;
    endtask

    // Advance one cycle, log DUT outputs and drive unit responses dly cycles after each req
    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        if (ifu_req) begin
            n_ifu++;
            if (t_ifu0 < 0) t_ifu0 = cyc;
            else if (t_ifu1 < 0) t_ifu1 = cyc;
            due_ifu = (dly_ifu > 0) ? cyc + dly_ifu : -1;
        end
        if (idu_req) begin
            n_idu++;
            if (t_idu0 < 0) t_idu0 = cyc;
            due_idu = (dly_idu > 0) ? cyc + dly_idu : -1;
        end
        if (exu_req) begin
            n_exu++;
            if (t_exu0 < 0) t_exu0 = cyc;
            due_exu = (dly_exu > 0) ? cyc + dly_exu : -1;
        end
        if (lsu_req) begin
            n_lsu++;
            if (t_lsu0 < 0) t_lsu0 = cyc;
            due_lsu = (dly_lsu > 0) ? cyc + dly_lsu : -1;
        end
        if (retired) begin
            n_ret++;
            if (t_wb0 < 0) begin
                t_wb0 = cyc;
                wb_rf = rf_we;
                wb_pc = pc_we;
            end
        end
        if (fault && t_fault < 0) t_fault = cyc;
        ifu_resp = (cyc == due_ifu);
        idu_resp = (cyc == due_idu);
        exu_resp = (cyc == due_exu);
        lsu_resp = (cyc == due_lsu);
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        run      = 1'b0;
        ifu_resp = 1'b0;
        idu_resp = 1'b0;
        exu_resp = 1'b0;
        lsu_resp = 1'b0;
        ebreak   = 1'b0;
        #2;
        chk("rst_outs", {20'd0, ifu_req, idu_req, exu_req, lsu_req, rf_we, pc_we,
                         retired, halted, fault, fault_stage}, 32'd0);
        chk("rst_instret", instret, 32'd0);
        @(posedge clock);
        #1;
        clear_log();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; run = 1'b0; ebreak = 1'b0; inst_type = 6'd1;
        ifu_resp = 1'b0; idu_resp = 1'b0; exu_resp = 1'b0; lsu_resp = 1'b0;
        dly_ifu = 1; dly_idu = 1; dly_exu = 1; dly_lsu = 1;
        clear_log();

        // ALU instruction with every unit answering one cycle after req
        do_reset();
        inst_type = 6'd1;
        run = 1'b1;
        for (int i = 0; i < 40 && t_ifu1 < 0; i++) tick();
        chk("alu_first_ifu", t_ifu0, 1);
        chk("alu_idu_t", t_idu0 - t_ifu0, 2);
        chk("alu_exu_t", t_exu0 - t_ifu0, 4);
        chk("alu_wb_t", t_wb0 - t_ifu0, 6);
        chk("alu_wb_rf", wb_rf, 1);
        chk("alu_wb_pc", wb_pc, 1);
        chk("alu_next_ifu", t_ifu1 - t_ifu0, 7);
        chk("alu_instret", instret, 1);
        chk("alu_no_lsu", n_lsu, 0);

        // Load goes through MEM and writes rd
        do_reset();
        inst_type = 6'd2;
        run = 1'b1;
        for (int i = 0; i < 40 && t_ifu1 < 0; i++) tick();
        chk("ld_lsu_t", t_lsu0 - t_ifu0, 6);
        chk("ld_wb_t", t_wb0 - t_ifu0, 8);
        chk("ld_wb_rf", wb_rf, 1);
        chk("ld_next_ifu", t_ifu1 - t_ifu0, 9);

        // Store goes through MEM but does not write rd
        do_reset();
        inst_type = 6'd3;
        run = 1'b1;
        for (int i = 0; i < 40 && t_ifu1 < 0; i++) tick();
        chk("st_lsu_t", t_lsu0 - t_ifu0, 6);
        chk("st_wb_t", t_wb0 - t_ifu0, 8);
        chk("st_wb_rf", wb_rf, 0);
        chk("st_wb_pc", wb_pc, 1);

        // EXU never answers: timeout after 4 wait cycles, then silent
        do_reset();
        inst_type = 6'd1;
        dly_exu = 0;
        run = 1'b1;
        for (int i = 0; i < 30 && t_fault < 0; i++) tick();
        chk("to_fault", fault, 1);
        chk("to_stage", fault_stage, 3);
        chk("to_fault_t", t_fault - t_exu0, 5);
        chk("to_no_retire", n_ret, 0);
        n_before = n_ifu + n_idu + n_exu + n_lsu;
        repeat (20) tick();
        chk("to_no_req", n_ifu + n_idu + n_exu + n_lsu - n_before, 0);
        chk("to_sticky", fault, 1);

        // EXU answers exactly in the timeout cycle: response wins
        do_reset();
        inst_type = 6'd1;
        dly_exu = 4;
        run = 1'b1;
        for (int i = 0; i < 40 && t_ifu1 < 0; i++) tick();
        chk("tr_no_fault", fault, 0);
        chk("tr_wb_t", t_wb0 - t_exu0, 5);
        chk("tr_retired", n_ret, 1);
        dly_exu = 1;

        // ebreak halts without retiring
        do_reset();
        inst_type = 6'd1;
        ebreak = 1'b1;
        run = 1'b1;
        repeat (20) tick();
        chk("eb_halted", halted, 1);
        chk("eb_no_retire", n_ret, 0);
        chk("eb_instret", instret, 0);
        chk("eb_one_fetch", n_ifu, 1);
        chk("eb_no_fault", fault, 0);
        ebreak = 1'b0;

        // Illegal class faults in DECODE
        do_reset();
        inst_type = 6'd0;
        run = 1'b1;
        repeat (20) tick();
        chk("il_fault", fault, 1);
        chk("il_stage", fault_stage, 2);
        chk("il_no_exu", n_exu, 0);
        chk("il_no_retire", n_ret, 0);

        // Dropping run during EXEC finishes the instruction and then idles
        do_reset();
        inst_type = 6'd1;
        run = 1'b1;
        for (int i = 0; i < 20 && t_exu0 < 0; i++) tick();
        run = 1'b0;
        repeat (20) tick();
        chk("rd_retired", n_ret, 1);
        chk("rd_one_fetch", n_ifu, 1);
        chk("rd_instret", instret, 1);

        // Reset asserted during MEM clears outputs at once and retires nothing
        do_reset();
        inst_type = 6'd2;
        run = 1'b1;
        for (int i = 0; i < 20 && t_lsu0 < 0; i++) tick();
        chk("mr_in_mem", lsu_req, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("mr_outs", {20'd0, ifu_req, idu_req, exu_req, lsu_req, rf_we, pc_we,
                        retired, halted, fault, fault_stage}, 32'd0);
        chk("mr_instret", instret, 0);
        repeat (3) tick();
        chk("mr_no_retire", n_ret, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
